// File: rtl/ahci_xfer_cntr_pkg.sv
// Shared constants and write-port FSM encoding for the AHCI transfer counter
// and the generic register-write requester.
package ahci_xfer_cntr_pkg;
  localparam int CNT_W        = 30;
  localparam int PRDBC_DW_IDX = 1;  // PRDBC lives in DWORD 1 of a command header
  localparam int HDR_DWORDS   = 8;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_WR   = 2'd2,
    WR_DONE = 2'd3
  } wr_state_e;
endpackage

// File: rtl/ahci_regs_wr_req.sv
// Request/grant single-DWORD register writer with a one-deep pending request.
// Address/data are captured when a write is launched from IDLE.
module ahci_regs_wr_req
  import ahci_xfer_cntr_pkg::*;
#(
  parameter int ADDRESS_BITS = 10,
  parameter int DATA_W       = 32
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDRESS_BITS-1:0] addr_in,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    regs_req,
  input  logic                    regs_gnt,
  output logic [ADDRESS_BITS-1:0] regs_addr,
  output logic                    regs_we,
  output logic [DATA_W-1:0]       regs_din,
  output logic                    busy,
  output logic                    done
);
  wr_state_e               state, state_nxt;
  logic                    pend;
  logic                    accept;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_W-1:0]       data_q;

  assign accept = (state == WR_IDLE) && (start || pend) && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE: if (accept) state_nxt = WR_REQ;
      WR_REQ:  if (abort) state_nxt = WR_IDLE;
               else if (regs_gnt) state_nxt = WR_WR;
      WR_WR:   state_nxt = WR_DONE;
      WR_DONE: state_nxt = WR_IDLE;
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      state     <= WR_IDLE;
      pend      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      regs_addr <= '0;
      regs_din  <= '0;
    end else begin
      state <= state_nxt;
      // abort drops a merged request; a write already granted still finishes
      if (abort || accept)
        pend <= 1'b0;
      else if (start && state != WR_IDLE)
        pend <= 1'b1;
      if (accept) begin
        addr_q <= addr_in;
        data_q <= data_in;
      end
      if (state == WR_REQ && regs_gnt && !abort) begin
        regs_addr <= addr_q;
        regs_din  <= data_q;
      end
    end
  end

  assign regs_req = (state == WR_REQ) || (state == WR_WR);
  assign regs_we  = (state == WR_WR);
  assign done     = (state == WR_DONE);
  assign busy     = (state != WR_IDLE) || pend;
endmodule

// File: rtl/ahci_xfer_cntr.sv
// Remaining-transfer counter and PRD byte count for AHCI port 0; PRDBC is
// written back to the active slot's command header through the shared port.
module ahci_xfer_cntr
  import ahci_xfer_cntr_pkg::*;
#(
  parameter int ADDRESS_BITS = 10,
  parameter int CLB_OFFS32   = 'h200
) (
  input  logic                    mclk,
  input  logic                    hba_rst_n,
  input  logic                    clear_xfer,
  input  logic [4:0]              cmd_slot,
  input  logic                    load_dma,
  input  logic [29:0]             dma_cnt,
  input  logic                    load_pio,
  input  logic [15:0]             pio_cnt,
  input  logic                    decr_dwc,
  input  logic [11:0]             decr_DXC_dw,
  input  logic                    update_prdbc,
  output logic [29:0]             xfer_cntr,
  output logic                    xfer_cntr_zero,
  output logic [29:0]             prdbc,
  output logic                    xfer_underflow,
  output logic                    regs_req,
  input  logic                    regs_gnt,
  output logic [ADDRESS_BITS-1:0] regs_addr,
  output logic                    regs_we,
  output logic [31:0]             regs_din,
  output logic                    prdbc_busy,
  output logic                    prdbc_done
);
  logic [CNT_W-1:0]        cntr_nxt, prdbc_nxt, decr_ext;
  logic                    unf_nxt;
  logic [ADDRESS_BITS-1:0] wr_addr;

  assign decr_ext = CNT_W'(decr_DXC_dw);

  always_comb begin
    cntr_nxt  = xfer_cntr;
    prdbc_nxt = prdbc;
    unf_nxt   = xfer_underflow;
    if (clear_xfer) begin
      cntr_nxt  = '0;
      prdbc_nxt = '0;
      unf_nxt   = 1'b0;
    end else if (load_dma) begin
      cntr_nxt = dma_cnt;
    end else if (load_pio) begin
      cntr_nxt = (CNT_W'(pio_cnt) + CNT_W'(3)) >> 2;
    end else if (decr_dwc) begin
      // overrun saturates at zero and is flagged; PRDBC still counts it
      if (decr_ext <= xfer_cntr) begin
        cntr_nxt = xfer_cntr - decr_ext;
      end else begin
        cntr_nxt = '0;
        unf_nxt  = 1'b1;
      end
      prdbc_nxt = prdbc + decr_ext;
    end
  end

  always_ff @(posedge mclk) begin
    if (!hba_rst_n) begin
      xfer_cntr      <= '0;
      prdbc          <= '0;
      xfer_underflow <= 1'b0;
      xfer_cntr_zero <= 1'b1;
    end else begin
      xfer_cntr      <= cntr_nxt;
      prdbc          <= prdbc_nxt;
      xfer_underflow <= unf_nxt;
      xfer_cntr_zero <= (xfer_cntr == '0);
    end
  end

  assign wr_addr = ADDRESS_BITS'(CLB_OFFS32 + int'(cmd_slot) * HDR_DWORDS + PRDBC_DW_IDX);

  ahci_regs_wr_req #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .DATA_W       (32)
  ) u_prdbc_wr (
    .gclk      (mclk),
    .grst_n    (hba_rst_n),
    .start     (update_prdbc),
    .abort     (clear_xfer),
    .addr_in   (wr_addr),
    .data_in   ({prdbc_nxt, 2'b00}),
    .regs_req  (regs_req),
    .regs_gnt  (regs_gnt),
    .regs_addr (regs_addr),
    .regs_we   (regs_we),
    .regs_din  (regs_din),
    .busy      (prdbc_busy),
    .done      (prdbc_done)
  );
endmodule
